uart_tx_io: RTL and testbench

//  Memory-mapped UART transmitter on the SOC data bus, downstream of the Processor load/store port; drives the SOC TXD pin.
//  CPU writes bytes into a small FIFO. An 8N1 shifter serialises them at a programmable baud divisor.

---
 rtl/uart_tx_io.sv | 123 ++++++++++++
 tb/tb_uart_tx_io.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_io.sv
// uart_tx_io: memory-mapped UART transmitter with a byte FIFO and programmable baud divisor.
// Define UART_TX_PARITY_EN for 8E1 frames; the default build sends 8N1.
module uart_tx_io #(
  parameter int DEPTH = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd1302
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        io_sel,
  input  logic [1:0]  io_addr,
  input  logic        io_wstrb,
  input  logic [31:0] io_wdata,
  input  logic        io_rstrb,
  output logic [31:0] io_rdata,
  output logic        TXD,
  output logic        tx_busy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [2:0] S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_STOP = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;
  localparam logic [2:0] S_AFTER = S_PARITY;
  logic par;
`else
  localparam logic [2:0] S_AFTER = S_STOP;
`endif
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [15:0] div, div_q, bit_cnt;
  logic [2:0] state, bit_idx;
  logic [7:0] shreg;
  logic overflow, wr, push_req, push, pop, full, empty, period_end, txd_n;
  logic [31:0] status;
  logic unused_hi;

  assign unused_hi = ^io_wdata[31:16];
  assign wr = io_sel & io_wstrb;
  assign push_req = wr & (io_addr == 2'd0);
  assign empty = count == '0;
  assign full = count == FULL_CNT;
  assign pop = (state == S_IDLE) & ~empty;
  assign push = push_req & (~full | pop);
  assign period_end = bit_cnt == 16'd0;
  assign tx_busy = ~empty | (state != S_IDLE);
  assign status = {28'd0, empty, overflow, full, tx_busy};
`ifdef UART_TX_PARITY_EN
  assign txd_n = state == S_START ? 1'b0 : state == S_DATA ? shreg[0] : state == S_PARITY ? par : 1'b1;
`else
  assign txd_n = state == S_START ? 1'b0 : state == S_DATA ? shreg[0] : 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= io_wdata[7:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      div <= DEFAULT_DIV;
      io_rdata <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      if (wr && io_addr == 2'd1 && io_wdata[2]) overflow <= 1'b0;
      if (push_req && !push) overflow <= 1'b1;
      if (wr && io_addr == 2'd2) div <= (io_wdata[15:0] == 16'd0) ? 16'd1 : io_wdata[15:0];
      if (io_sel && io_rstrb) io_rdata <= io_addr == 2'd1 ? status : io_addr == 2'd2 ? {16'd0, div} : 32'd0;
    end
  end

  // TXD is registered from the current state, so it trails the FSM by one cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      shreg <= '0;
      div_q <= DEFAULT_DIV;
      bit_cnt <= '0;
      bit_idx <= '0;
      TXD <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par <= 1'b0;
`endif
    end else begin
      TXD <= txd_n;
      if (state == S_IDLE) begin
        if (pop) begin
          state <= S_START;
          shreg <= mem[rd_ptr];
          div_q <= div;
          bit_cnt <= div - 16'd1;
`ifdef UART_TX_PARITY_EN
          par <= ^mem[rd_ptr];
`endif
        end
      end else if (!period_end) begin
        bit_cnt <= bit_cnt - 16'd1;
      end else begin
        bit_cnt <= div_q - 16'd1;
        case (state)
          S_START: begin
            state <= S_DATA;
            bit_idx <= '0;
          end
          S_DATA: begin
            shreg <= shreg >> 1;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= S_AFTER;
          end
`ifdef UART_TX_PARITY_EN
          S_PARITY: state <= S_STOP;
`endif
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_io.sv
// tb_uart_tx_io: randomized self-checking bench comparing TXD against a bit-level frame model.
module tb_uart_tx_io;
  localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FBITS = 11;
`else
  localparam int FBITS = 10;
`endif
  logic clk = 1'b0, resetn = 1'b0, io_sel = 1'b0, io_wstrb = 1'b0, io_rstrb = 1'b0;
  logic [1:0] io_addr = 2'd0;
  logic [31:0] io_wdata = 32'd0;
  logic [31:0] io_rdata;
  logic TXD, tx_busy;
  int compared = 0, mismatched = 0, cyc = 0, c_n = 0, frames_end = 0;
  logic txq[$], busyq[$], exp_q[$];
  logic [7:0] fb[$];
  int fd[$];
  logic ws[$];
  logic [1:0] wa[$];
  logic [31:0] wd[$];

  uart_tx_io #(.DEPTH(DEPTH), .DEFAULT_DIV(16'd1302)) dut (
    .clk(clk), .resetn(resetn), .io_sel(io_sel), .io_addr(io_addr), .io_wstrb(io_wstrb),
    .io_wdata(io_wdata), .io_rstrb(io_rstrb), .io_rdata(io_rdata), .TXD(TXD), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk); io_sel = 1'b1; io_wstrb = 1'b1; io_addr = a; io_wdata = d;
    @(negedge clk); io_sel = 1'b0; io_wstrb = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk); io_sel = 1'b1; io_rstrb = 1'b1; io_addr = a;
    @(negedge clk); io_sel = 1'b0; io_rstrb = 1'b0; d = io_rdata;
  endtask

  task automatic drive_burst();
    foreach (ws[i]) begin
      @(negedge clk);
      if (i == 0) c_n = cyc + 1;
      io_sel = ws[i]; io_wstrb = ws[i]; io_addr = wa[i]; io_wdata = wd[i];
    end
    @(negedge clk); io_sel = 1'b0; io_wstrb = 1'b0;
  endtask

  task automatic capture(input int n);
    txq.delete(); busyq.delete();
    repeat (n) begin
      @(negedge clk);
      txq.push_back(TXD); busyq.push_back(tx_busy);
    end
  endtask

  task automatic run_wave(input int n);
    fork
      drive_burst();
      begin @(negedge clk); @(posedge clk); capture(n); end
    join
  endtask

  // sample 0 is the first negedge after the first write; the first start bit appears at sample 2
  function automatic void build_exp(input int n);
    exp_q.delete(); exp_q.push_back(1'b1); exp_q.push_back(1'b1);
    foreach (fb[i]) begin
      logic bits[$];
      bits = {1'b0};
      for (int b = 0; b < 8; b++) bits.push_back(fb[i][b]);
`ifdef UART_TX_PARITY_EN
      bits.push_back(^fb[i]);
`endif
      bits.push_back(1'b1);
      foreach (bits[j]) repeat (fd[i]) exp_q.push_back(bits[j]);
      if (i < fb.size() - 1) exp_q.push_back(1'b1);
    end
    frames_end = exp_q.size();
    while (exp_q.size() < n) exp_q.push_back(1'b1);
  endfunction

  function automatic int first_diff();
    for (int i = 0; i < exp_q.size(); i++) if (i >= txq.size() || txq[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic test_reset();
    logic [31:0] r;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    compared++; if (TXD !== 1'b1) begin mismatched++; $display("FAIL reset_txd: got %b want 1", TXD); end
    compared++; if (tx_busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
    compared++; if (io_rdata !== 32'd0) begin mismatched++; $display("FAIL reset_rdata: got %h want 0", io_rdata); end
    @(negedge clk); resetn = 1'b1;
    bus_read(2'd1, r);
    compared++; if (r !== 32'h8) begin mismatched++; $display("FAIL reset_status: got %h want 8", r); end
    bus_read(2'd2, r);
    compared++; if (r !== 32'd1302) begin mismatched++; $display("FAIL reset_div: got %0d want 1302", r); end
    bus_read(2'd3, r);
    compared++; if (r !== 32'd0) begin mismatched++; $display("FAIL reserved_read: got %h want 0", r); end
  endtask

  task automatic test_single_frame();
    int d, n, dv;
    logic [7:0] b;
    bus_write(2'd2, 32'd4);
    ws = {1'b1}; wa = {2'd0}; wd = {32'h55}; fb = {8'h55}; fd = {4};
    n = 2 + FBITS * 4 + 4;
    run_wave(n); build_exp(n); d = first_diff();
    compared++; if (d != -1) begin mismatched++; $display("FAIL frame_55: sample %0d got %b want %b", d, txq[d], exp_q[d]); end
    compared++; if (txq[1] !== 1'b1 || txq[2] !== 1'b0) begin mismatched++; $display("FAIL start_latency: samples1,2 got %b%b want 10", txq[1], txq[2]); end
    dv = $urandom_range(1, 6); b = 8'($urandom_range(0, 255));
    bus_write(2'd2, 32'(dv));
    ws = {1'b1}; wa = {2'd0}; wd = {32'(b)}; fb = {b}; fd = {dv};
    n = 2 + FBITS * dv + 4;
    run_wave(n); build_exp(n); d = first_diff();
    compared++; if (d != -1) begin mismatched++; $display("FAIL frame_rand %h div %0d: sample %0d got %b want %b", b, dv, d, txq[d], exp_q[d]); end
  endtask

  task automatic test_back_to_back();
    int d, n;
    logic [7:0] b0, b1;
    bus_write(2'd2, 32'd2);
    ws = {1'b1, 1'b1, 1'b1}; wa = {2'd0, 2'd0, 2'd0}; wd = {32'h41, 32'h42, 32'h43};
    fb = {8'h41, 8'h42, 8'h43}; fd = {2, 2, 2};
    n = 2 + 3 * FBITS * 2 + 2 + 6;
    run_wave(n); build_exp(n); d = first_diff();
    compared++; if (d != -1) begin mismatched++; $display("FAIL b2b_abc: sample %0d got %b want %b", d, txq[d], exp_q[d]); end
    compared++; if (busyq[frames_end-2] !== 1'b1) begin mismatched++; $display("FAIL busy_last_stop: got %b want 1", busyq[frames_end-2]); end
    compared++; if (busyq[frames_end] !== 1'b0) begin mismatched++; $display("FAIL busy_after_stop: got %b want 0", busyq[frames_end]); end
    b0 = 8'($urandom_range(0, 255)); b1 = 8'($urandom_range(0, 255));
    wd = {32'(b0), 32'(b1), 32'h07}; fb = {b0, b1, 8'h07};
    run_wave(n); build_exp(n); d = first_diff();
    compared++; if (d != -1) begin mismatched++; $display("FAIL b2b_rand: sample %0d got %b want %b", d, txq[d], exp_q[d]); end
  endtask

  task automatic test_overflow();
    int d, n;
    logic [31:0] r;
    logic [7:0] x;
    bus_write(2'd2, 32'd100);
    ws.delete(); wa.delete(); wd.delete(); fb.delete(); fd.delete();
    for (int i = 0; i < DEPTH + 2; i++) begin
      ws.push_back(1'b1); wa.push_back(2'd0); wd.push_back(32'($urandom_range(0, 255)));
      if (i < DEPTH + 1) begin fb.push_back(wd[i][7:0]); fd.push_back(100); end
    end
    x = 8'($urandom_range(0, 255));
    fb.push_back(x); fd.push_back(100);
    n = 2 + (DEPTH + 2) * FBITS * 100 + (DEPTH + 1) + 10;
    fork
      begin
        drive_burst();
        bus_read(2'd1, r);
        compared++; if (r !== 32'h7) begin mismatched++; $display("FAIL status_full_ovf: got %h want 7", r); end
        bus_write(2'd1, 32'h4);
        bus_read(2'd1, r);
        compared++; if (r !== 32'h3) begin mismatched++; $display("FAIL status_ovf_clr: got %h want 3", r); end
        while (cyc < c_n + FBITS * 100 + 1) @(negedge clk);
        io_sel = 1'b1; io_wstrb = 1'b1; io_addr = 2'd0; io_wdata = 32'(x);
        @(negedge clk); io_sel = 1'b0; io_wstrb = 1'b0;
        bus_read(2'd1, r);
        compared++; if (r !== 32'h3) begin mismatched++; $display("FAIL status_full_pushpop: got %h want 3", r); end
      end
      begin @(negedge clk); @(posedge clk); capture(n); end
    join
    build_exp(n); d = first_diff();
    compared++; if (d != -1) begin mismatched++; $display("FAIL overflow_frames: sample %0d got %b want %b", d, txq[d], exp_q[d]); end
  endtask

  task automatic test_div_change();
    int d, n;
    logic [31:0] r;
    logic [7:0] a, b;
    bus_write(2'd2, 32'd0);
    bus_read(2'd2, r);
    compared++; if (r !== 32'd1) begin mismatched++; $display("FAIL div_zero: got %0d want 1", r); end
    bus_write(2'd2, 32'd4);
    a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255));
    ws.delete(); wa.delete(); wd.delete();
    ws.push_back(1'b1); wa.push_back(2'd0); wd.push_back(32'(a));
    repeat (14) begin ws.push_back(1'b0); wa.push_back(2'd0); wd.push_back(32'd0); end
    ws.push_back(1'b1); wa.push_back(2'd2); wd.push_back(32'd8);
    ws.push_back(1'b1); wa.push_back(2'd0); wd.push_back(32'(b));
    fb = {a, b}; fd = {4, 8};
    n = 2 + FBITS * 4 + 1 + FBITS * 8 + 5;
    run_wave(n); build_exp(n); d = first_diff();
    compared++; if (d != -1) begin mismatched++; $display("FAIL div_midframe: sample %0d got %b want %b", d, txq[d], exp_q[d]); end
    bus_read(2'd2, r);
    compared++; if (r !== 32'd8) begin mismatched++; $display("FAIL div_readback: got %0d want 8", r); end
  endtask

  task automatic test_reset_midframe();
    int d, n;
    logic [31:0] r;
    logic [7:0] a;
    bus_write(2'd2, 32'd4);
    a = 8'($urandom_range(0, 255));
    ws = {1'b1, 1'b1, 1'b1}; wa = {2'd0, 2'd0, 2'd0};
    wd = {32'(a), 32'($urandom_range(0, 255)), 32'($urandom_range(0, 255))};
    fb = {a}; fd = {4};
    build_exp(0);
    drive_burst();
    while (cyc < c_n + 18) @(negedge clk);
    compared++; if (TXD !== exp_q[18]) begin mismatched++; $display("FAIL bit3_before_reset: got %b want %b", TXD, exp_q[18]); end
    resetn = 1'b0;
    #1;
    compared++; if (TXD !== 1'b1) begin mismatched++; $display("FAIL abort_txd: got %b want 1", TXD); end
    compared++; if (tx_busy !== 1'b0) begin mismatched++; $display("FAIL abort_busy: got %b want 0", tx_busy); end
    @(negedge clk); resetn = 1'b1;
    bus_read(2'd1, r);
    compared++; if (r !== 32'h8) begin mismatched++; $display("FAIL abort_status: got %h want 8", r); end
    capture(100);
    exp_q.delete(); repeat (100) exp_q.push_back(1'b1);
    d = first_diff();
    compared++; if (d != -1) begin mismatched++; $display("FAIL no_frames_after_reset: sample %0d got %b want 1", d, txq[d]); end
    bus_write(2'd2, 32'd2);
    ws = {1'b1}; wa = {2'd0}; wd = {32'h07}; fb = {8'h07}; fd = {2};
    n = 2 + FBITS * 2 + 4;
    run_wave(n); build_exp(n); d = first_diff();
    compared++; if (d != -1) begin mismatched++; $display("FAIL frame_07: sample %0d got %b want %b", d, txq[d], exp_q[d]); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_div_change();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
